// File: rtl/nanorisc_pkg.sv
// nanorisc_pkg
// Shared NanoRisc definitions: the 3-bit logic-unit opcode type and its
// LOGIC_OP_* encodings. The decoder uses the same type to build in_op, so
// both sides agree on the encoding.
package nanorisc_pkg;

  localparam int unsigned LOGIC_OP_W = 3;

  typedef enum logic [LOGIC_OP_W-1:0] {
    LOGIC_OP_AND   = 3'd0,
    LOGIC_OP_OR    = 3'd1,
    LOGIC_OP_XOR   = 3'd2,
    LOGIC_OP_NAND  = 3'd3,
    LOGIC_OP_NOR   = 3'd4,
    LOGIC_OP_XNOR  = 3'd5,
    LOGIC_OP_NOT_A = 3'd6,
    LOGIC_OP_PASS_A = 3'd7
  } logic_op_t;

endpackage

// File: rtl/logic_op_core.sv
// logic_op_core
// Purely combinational bitwise operation with result flags.
// Ports:
//   a, b    : WIDTH-bit operands (b is ignored by NOT A and PASS A)
//   op      : operation code (logic_op_t)
//   result  : WIDTH-bit operation result
//   zero    : 1 when result is all zeros
//   parity  : XOR-reduction of result
module logic_op_core
  import nanorisc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic_op_t        op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity
);

  always_comb begin
    result = '0;
    case (op)
      LOGIC_OP_AND:    result = a & b;
      LOGIC_OP_OR:     result = a | b;
      LOGIC_OP_XOR:    result = a ^ b;
      LOGIC_OP_NAND:   result = ~(a & b);
      LOGIC_OP_NOR:    result = ~(a | b);
      LOGIC_OP_XNOR:   result = ~(a ^ b);
      LOGIC_OP_NOT_A:  result = ~a;
      LOGIC_OP_PASS_A: result = a;
      default:         result = '0;
    endcase
  end

  assign zero   = ~|result;
  assign parity = ^result;

endmodule

// File: rtl/logic_unit.sv
// logic_unit
// Two-stage elastic bitwise logic unit with valid/ready handshakes on both
// sides and a synchronous flush.
//   S1 registers operands and opcode; S2 registers the computed result,
//   zero/parity flags and opcode echo. out_* come straight from S2.
// Ports:
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   flush                 : synchronous; clears both valid flags
//   in_valid/in_ready     : operand-side handshake
//   in_a, in_b, in_op     : operands and 3-bit operation code
//   out_valid/out_ready   : result-side handshake
//   out_result            : WIDTH-bit result
//   out_zero, out_parity  : result all-zero flag, XOR-reduction of result
//   out_op                : opcode that produced this result
module logic_unit
  import nanorisc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_parity,
  output logic [2:0]       out_op
);

  // Stage 1 state
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic_op_t        s1_op;

  // Stage 2 state
  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic             s2_zero;
  logic             s2_parity;
  logic [2:0]       s2_op;

  // Combinational result between the stages
  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_parity;

  logic s2_take;
  logic s1_take;
  logic in_xfer;
  logic s1_to_s2;

  assign s2_take  = !s2_valid || out_ready;
  assign s1_take  = !s1_valid || s2_take;
  // Gating with reset keeps the producer from handing over an operand while
  // the pipeline is being cleared asynchronously.
  assign in_ready = s1_take && !reset;
  assign in_xfer  = in_valid && in_ready;
  assign s1_to_s2 = s1_valid && s2_take;

  logic_op_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (core_result),
    .zero   (core_zero),
    .parity (core_parity)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= LOGIC_OP_AND;
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_zero   <= 1'b0;
      s2_parity <= 1'b0;
      s2_op     <= '0;
    end else if (flush) begin
      // Only validity is discarded; data registers keep their contents.
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_to_s2) begin
        s2_result <= core_result;
        s2_zero   <= core_zero;
        s2_parity <= core_parity;
        s2_op     <= s1_op;
      end
      if (s2_take) begin
        s2_valid <= s1_valid;
      end
      if (in_xfer) begin
        s1_a  <= in_a;
        s1_b  <= in_b;
        s1_op <= logic_op_t'(in_op);
      end
      if (s1_take) begin
        s1_valid <= in_valid;
      end
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_zero   = s2_zero;
  assign out_parity = s2_parity;
  assign out_op     = s2_op;

endmodule

// File: tb/tb_logic_unit.sv
// tb_logic_unit
// Scoreboard bench for logic_unit: an 8-bit instance driven by directed and
// random stimulus, plus a 1-bit instance for the original AND-gate case.
// Expected results come from a per-bit truth-table reference model.
module tb_logic_unit;

  typedef struct {
    logic [7:0] r;
    logic       z;
    logic       p;
    logic [2:0] op;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  // 8-bit instance
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [2:0] in_op = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_result;
  logic       out_zero;
  logic       out_parity;
  logic [2:0] out_op;

  // 1-bit instance
  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [0:0] in_a1 = '0;
  logic [0:0] in_b1 = '0;
  logic [2:0] in_op1 = '0;
  logic       out_valid1;
  logic       out_ready1 = 1'b1;
  logic [0:0] out_result1;
  logic       out_zero1;
  logic       out_parity1;
  logic [2:0] out_op1;

  int tests = 0;
  int fails = 0;

  exp_t q[$];
  exp_t q1[$];

  always #5 clock = ~clock;

  logic_unit #(.WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_parity (out_parity),
    .out_op     (out_op)
  );

  logic_unit #(.WIDTH(1)) dut1 (
    .clock      (clock),
    .reset      (reset),
    .flush      (1'b0),
    .in_valid   (in_valid1),
    .in_ready   (in_ready1),
    .in_a       (in_a1),
    .in_b       (in_b1),
    .in_op      (in_op1),
    .out_valid  (out_valid1),
    .out_ready  (out_ready1),
    .out_result (out_result1),
    .out_zero   (out_zero1),
    .out_parity (out_parity1),
    .out_op     (out_op1)
  );

  // Truth table per op, indexed by {a_bit, b_bit}.
  function automatic logic [3:0] truth(input logic [2:0] op);
    case (op)
      3'd0: truth = 4'b1000;  // AND
      3'd1: truth = 4'b1110;  // OR
      3'd2: truth = 4'b0110;  // XOR
      3'd3: truth = 4'b0111;  // NAND
      3'd4: truth = 4'b0001;  // NOR
      3'd5: truth = 4'b1001;  // XNOR
      3'd6: truth = 4'b0011;  // NOT A
      default: truth = 4'b1100;  // PASS A
    endcase
  endfunction

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] op, input int w);
    exp_t e;
    logic [3:0] t;
    int ones;
    t = truth(op);
    e.r = '0;
    ones = 0;
    for (int i = 0; i < w; i++) begin
      e.r[i] = t[{a[i], b[i]}];
      if (e.r[i]) ones++;
    end
    e.z = (ones == 0);
    e.p = (ones % 2 == 1);
    e.op = op;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    repeat (5) step();
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
  endtask

  initial begin
    logic [17:0] vpat;
    logic [31:0] rnd;
    int          waited;

    // Scoreboard: pops on every output transfer, pushes on every accepted
    // input, and forgets in-flight entries on flush or reset.
    fork
      forever begin
        exp_t e;
        @(negedge clock);
        if (reset) begin
          q.delete();
          q1.delete();
        end else begin
          if (out_valid && out_ready) begin
            if (q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL sb_unexpected actual=%0h required=none", out_result);
            end else begin
              e = q.pop_front();
              chk("sb_result8", 64'({out_result, out_zero, out_parity, out_op}),
                  64'({e.r, e.z, e.p, e.op}));
            end
          end
          if (flush) q.delete();
          else if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_op, 8));

          if (out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL sb1_unexpected actual=%0h required=none", out_result1);
            end else begin
              e = q1.pop_front();
              chk("sb_result1", 64'({out_result1, out_zero1, out_parity1, out_op1}),
                  64'({e.r[0], e.z, e.p, e.op}));
            end
          end
          if (in_valid1 && in_ready1)
            q1.push_back(model({7'd0, in_a1}, {7'd0, in_b1}, in_op1, 1));
        end
      end
    join_none

    // Reset state
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_fields", 64'({out_result, out_zero, out_parity, out_op}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    step();
    reset = 1'b0;
    step();

    // Truth coverage
    for (int op = 0; op < 8; op++) begin
      send(8'hC5, 8'h3A, 3'(op));
      step();
    end
    drain();

    // Throughput / latency
    for (int i = 0; i < 18; i++) begin
      if (i < 16) send(8'(i), 8'h0F, 3'd2);
      else in_valid = 1'b0;
      @(negedge clock);
      vpat[i] = out_valid;
      step();
    end
    chk("tp_valid_pattern", 64'(vpat), 64'h3FFFC);
    drain();

    // Backpressure
    out_ready = 1'b0;
    send(8'hFF, 8'h81, 3'd0);
    step();
    send(8'h10, 8'h01, 3'd1);
    step();
    send(8'h00, 8'h00, 3'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold", 64'({out_valid, out_result, out_op}), 64'({1'b1, 8'h81, 3'd0}));
      step();
    end
    out_ready = 1'b1;
    waited = 0;
    @(negedge clock);
    while (!in_ready && waited < 10) begin
      waited++;
      step();
      @(negedge clock);
    end
    chk("bp_release_accept", 64'(in_ready), 64'd1);
    step();
    drain();

    // Flush
    send(8'h0F, 8'hF0, 3'd1);
    step();
    send(8'hAA, 8'h55, 3'd2);
    step();
    send(8'h12, 8'h34, 3'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    step();
    send(8'h3C, 8'h0F, 3'd5);
    step();
    drain();
    chk("flush_queue_empty", 64'(q.size()), 64'd0);

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    send(8'h11, 8'h22, 3'd1);
    step();
    send(8'h33, 8'h44, 3'd2);
    step();
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("areset_out_valid", 64'(out_valid), 64'd0);
    chk("areset_out_result", 64'(out_result), 64'd0);
    chk("areset_in_ready", 64'(in_ready), 64'd0);
    step();
    @(negedge clock);
    chk("areset_in_ready_hold", 64'(in_ready), 64'd0);
    #2;
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    @(negedge clock);
    chk("areset_post_out_valid", 64'(out_valid), 64'd0);
    step();
    send(8'h5A, 8'hFF, 3'd3);
    step();
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rnd = $urandom;
      in_valid  = (rnd[3:0] < 4'd11);
      out_ready = (rnd[7:4] < 4'd11);
      flush     = (rnd[12:8] == 5'd0);
      in_op     = rnd[15:13];
      in_a      = rnd[23:16];
      in_b      = rnd[31:24];
      step();
    end
    drain();
    chk("rand_queue_empty", 64'(q.size()), 64'd0);

    // 1-bit instance: the original AND gate
    for (int i = 0; i < 4; i++) begin
      in_valid1 = 1'b1;
      in_a1     = 1'(i >> 1);
      in_b1     = 1'(i);
      in_op1    = 3'd0;
      step();
    end
    in_valid1 = 1'b0;
    repeat (5) step();
    chk("w1_queue_empty", 64'(q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/logic_unit.md
# logic_unit

Parametrised, pipelined bitwise logic unit for the NanoRisc datapath, generalising the two-input 1-bit AND gate to WIDTH-bit operands and eight selectable logic operations. It is a two-stage elastic pipeline with valid/ready handshakes on both sides and a synchronous flush. It sits between the decode/operand-read stage and writeback, alongside the adder, and reports zero and parity flags with each result.

## Interface
- WIDTH, 8, operand and result width in bits; legal values are 1 to 64.
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; clears the whole pipeline.
- in_valid  input  1  operand set is valid.
- in_ready  output  1  unit accepts an operand set this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  operation code (see Operation).
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  WIDTH  operation result.
- out_zero  output  1  1 when out_result is all zeros.
- out_parity  output  1  XOR-reduction of out_result.
- out_op  output  3  echo of the operation code that produced this result.

## Operation
- Operation codes:
  - 0 AND, 1 OR, 2 XOR, 3 NAND.
  - 4 NOR, 5 XNOR, 6 NOT A (in_b ignored), 7 PASS A.
- Stage 1 (S1) registers in_a, in_b and in_op, plus the flag s1_valid.
- Stage 2 (S2):
  - Computes the result from the S1 registers.
  - Registers result, zero, parity and op, plus the flag s2_valid.
  - out_* are driven directly from the S2 registers.
- Advance rules:
  - s2_take = !s2_valid || out_ready.
  - s1_take = !s1_valid || s2_take.
  - in_ready = s1_take, and is 0 while reset is asserted.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - S1 moves to S2 when s1_valid && s2_take.
- While out_valid=1 and out_ready=0, all out_* hold stable.
- Data registers load only on a transfer; the valid flags carry validity.
- in_op values outside 0–7 cannot occur because the field is 3 bits wide. out_op is the exact registered code.
- Flush:
  - On a rising edge with flush=1, s1_valid and s2_valid are cleared to 0.
  - An input presented that cycle is dropped, even though in_ready may read 1.
  - Flush takes priority over accept and advance.
  - Data registers keep their values; only the valid flags clear.
- Reset (asynchronous): s1_valid=0, s2_valid=0, out_result=0, out_zero=0, out_parity=0, out_op=0.

## Timing
- Latency: an operand accepted at edge N produces out_valid=1 after edge N+1 (two register stages). There is no combinational path from in_* to out_*.
- Throughput: one result per cycle while out_ready=1.
- in_ready depends combinationally on out_ready. There is no combinational path from in_valid to in_ready.
- Full: s1_valid=1, s2_valid=1 and out_ready=0 force in_ready=0. Nothing is lost or overwritten.
- Simultaneous events:
  - With S2 full and out_ready=1, S2 loads from S1 on the same edge, and S1 loads a new input if in_valid=1.
- Reset asserted mid-operation: all in-flight results are discarded immediately, without waiting for a clock edge. After release, the first accepted input appears two edges later.

## Structure
- Shared package nanorisc_pkg holds:
  - the LOGIC_OP_* opcode constants (AND=0 … PASS_A=7);
  - the 3-bit opcode typedef, also used by the decoder.
- One sub-module, logic_op_core: purely combinational, inputs (a, b, op), outputs (result, zero, parity), parametrised by WIDTH. logic_unit instantiates it between S1 and S2.
- The handshake and flush logic stays in logic_unit.

## Test plan
- Truth coverage, WIDTH=8, out_ready=1:
  - Stimulus: a=8'hC5, b=8'h3A, ops 0–7 on consecutive cycles.
  - Required results: 00, FF, FF, FF, 00, 00, 3A, C5.
  - Required zero flags: 1,0,0,0,1,1,0,0.
  - Required parity flags: 0,0,0,0,0,0,0,0.
- Throughput/latency: 16 back-to-back XOR inputs with a=i, b=8'h0F.
  - First out_valid two edges after the first accept.
  - 16 consecutive valid cycles, each result equal to i^8'h0F.
- Backpressure:
  - Hold out_ready=0 for 5 cycles while feeding AND of FF/81 and then OR of 10/01.
  - in_ready must drop after two accepts, and out_* must stay stable at 81.
  - After releasing out_ready, the order must be 81, then 11.
- Flush:
  - Load two ops, then pulse flush with in_valid=1.
  - out_valid must be 0 on the next cycle, and no dropped result may ever appear.
  - The next input must emerge normally.
- Async reset mid-stream: assert reset between clock edges with both stages full.
  - out_valid=0 and out_result=0 immediately.
  - in_ready=0 during reset.
  - Normal operation resumes after release.
- WIDTH=1 sanity check (the original gate's scenario): a/b = 00, 01, 10, 11 with op AND must yield 0, 0, 0, 1.
